wr_demux4_32x: RTL and testbench
================================

Name: wr_demux4_32x

Overview:
- Write-side counterpart of the 32-bit 4:1 read-select path: steers one incoming 32-bit word to one of four destination lanes, selected by a 2-bit select.
- Each lane has a one-entry holding register with a valid/ready handshake, so a stalled destination does not block writes to the other lanes.
- Sits between the write-back source and four 32-bit sink blocks (register banks or per-unit latches).
- Keeps a per-lane count of accepted words for debug and verification.

Parameters:
- WIDTH, 32, data width of input and each lane.
- CNT_W, 8, width of each per-lane accepted-word counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source has a word this cycle.
- in_sel  input  2  destination lane index, 0..3.
- in_data  input  WIDTH  word to steer.
- in_ready  output  1  block accepts the word this cycle (combinational).
- out_data0, out_data1, out_data2, out_data3  output  WIDTH each  lane holding-register contents.
- out_valid  output  4  bit k set: lane k holds an undelivered word.
- out_ready  input  4  bit k set: sink k accepts lane k this cycle.
- cnt0, cnt1, cnt2, cnt3  output  CNT_W each  accepted-word count per lane.

Behaviour:
- Reset, when reset=1 at a rising edge:
  - out_valid=4'b0000.
  - out_data0..3=0.
  - cnt0..3=0.
  - Parity bits (if present) = 0.
  - Reset overrides all same-cycle handshakes; any pending words are discarded.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. It depends only on the selected lane and is valid even when in_valid=0.
- Accept: accept = in_valid & in_ready. On accept, at the next edge:
  - out_data[in_sel] <= in_data.
  - out_valid[in_sel] <= 1.
  - cnt[in_sel] <= cnt[in_sel]+1.
- Latency: exactly 1 cycle from accept to out_valid.
- Drain: lane k delivers when out_valid[k] & out_ready[k]. At the next edge out_valid[k] <= 0, unless the same lane is loaded in that cycle.
- Same-lane load and drain in one cycle: out_valid[k] stays 1 and out_data[k] takes the new word. This gives full throughput of one word per cycle per lane.
- Loads and drains on different lanes in the same cycle are independent.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is held constant. Non-selected lanes never change except by their own drain.
- out_data[k] keeps its last value after a drain; it is not cleared.
- When in_valid=0, no state changes except drains.
- Counter at its maximum (2^CNT_W-1) plus an accept wraps to 0.
- No internal state machine beyond per-lane valid flags. Each lane follows EMPTY→FULL on accept and FULL→EMPTY on drain-without-reload.

Optional Feature:
- Macro: WR_DEMUX_PARITY_EN.
- Defined:
  - Adds output out_par, 4 bits.
  - Bit k = XOR-reduce of the word loaded into lane k, registered together with out_data[k] and held with it.
  - Reset value 0.
- Undefined: out_par port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert reset for 2 cycles with in_valid=1 → out_valid=0000, all out_data=0, all cnt=0, in_ready=1.
- Basic steering: in_valid=1, in_sel=2, in_data=32'hDEADBEEF, out_ready=0000 → next cycle out_valid=0100, out_data2=DEADBEEF, cnt2=1; other lanes unchanged.
- Backpressure: lane 2 full with out_ready[2]=0, then in_sel=2 with in_data=32'h12345678 → in_ready=0; out_data2 stays DEADBEEF for 5 cycles and cnt2 stays 1. Then in_sel=1 → in_ready=1 and lane 1 loads.
- Full throughput: lane 0 with out_ready[0]=1 held, 4 consecutive words 1,2,3,4 → in_ready=1 every cycle; out_data0 shows 1,2,3,4 on successive cycles; out_valid[0] stays 1 throughout; cnt0=4.
- Wrap and mid-operation reset: 256 accepts to lane 3 with CNT_W=8 → cnt3=0. Then load lanes 0 and 1 and assert reset in the same cycle as a new accept → out_valid=0000 and no counter increments.
- Parity (WR_DEMUX_PARITY_EN defined): load 32'h00000007 to lane 1 → out_par[1]=1; load 32'h00000003 → out_par[1]=0.

Source files
------------

// File: rtl/wr_demux4_32x.sv
// One-to-four write steering with a single-entry valid/ready holding register per lane.
// Define WR_DEMUX_PARITY_EN to add out_par: per-lane parity of the held word.
module wr_demux4_32x #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`ifdef WR_DEMUX_PARITY_EN
  ,
  output logic [3:0]       out_par
`endif
);

  localparam int unsigned LANES = 4;

  logic [WIDTH-1:0] r_data [LANES];
  logic [CNT_W-1:0] r_cnt  [LANES];
  logic [3:0]       r_valid;
  logic [3:0]       w_load;
  logic [3:0]       w_drain;
  logic             w_ready;

  // A lane can take a word when empty or when its current word leaves this cycle.
  always_comb begin
    w_ready         = ~r_valid[in_sel] | out_ready[in_sel];
    w_load          = 4'b0000;
    w_load[in_sel]  = in_valid & w_ready;
    w_drain         = r_valid & out_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 4'b0000;
      for (int k = 0; k < LANES; k++) begin
        r_data[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (w_load[k]) begin
          r_data[k]  <= in_data;
          r_valid[k] <= 1'b1;
          r_cnt[k]   <= r_cnt[k] + CNT_W'(1);
        end else if (w_drain[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef WR_DEMUX_PARITY_EN
  logic [3:0] r_par;

  // Parity is captured alongside the word so it stays aligned with out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 4'b0000;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (w_load[k]) begin
          r_par[k] <= ^in_data;
        end
      end
    end
  end

  assign out_par = r_par;
`endif

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign cnt0      = r_cnt[0];
  assign cnt1      = r_cnt[1];
  assign cnt2      = r_cnt[2];
  assign cnt3      = r_cnt[3];

endmodule

// File: tb/tb_wr_demux4_32x.sv
// Bench for wr_demux4_32x: directed scenarios plus randomized traffic against a lane-occupancy model.
// Parity checks compile in when WR_DEMUX_PARITY_EN is defined.
module tb_wr_demux4_32x;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;
  localparam int          CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] out_data [4];
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [CNT_W-1:0] cnt [4];
`ifdef WR_DEMUX_PARITY_EN
  logic [3:0]       out_par;
`endif

  int checks = 0;
  int errors = 0;

  // Model: each lane is a one-slot mailbox with an accept tally.
  bit          m_full  [4];
  logic [31:0] m_word  [4];
  int          m_count [4];
  bit          m_par   [4];
  logic        obs_ready;
  bit          exp_ready;

  always #5 clk = ~clk;

  wr_demux4_32x #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .out_data0(out_data[0]), .out_data1(out_data[1]),
    .out_data2(out_data[2]), .out_data3(out_data[3]),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt[0]), .cnt1(cnt[1]), .cnt2(cnt[2]), .cnt3(cnt[3])
`ifdef WR_DEMUX_PARITY_EN
    , .out_par(out_par)
`endif
  );

  // Drive one cycle, capture in_ready before the edge, advance the model, settle after the edge.
  task automatic apply(input bit rst, input bit v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] r);
    reset = rst; in_valid = v; in_sel = s; in_data = d; out_ready = r;
    #1;
    obs_ready = in_ready;
    exp_ready = !m_full[s] || r[s];
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_full[k] = 0; m_word[k] = '0; m_count[k] = 0; m_par[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (m_full[k] && r[k]) m_full[k] = 0;
      if (v && exp_ready) begin
        m_full[s]  = 1;
        m_word[s]  = d;
        m_count[s] = (m_count[s] + 1) % CNT_MOD;
        m_par[s]   = ^d;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 2'd3, 32'hFFFF_FFFF, 4'b0000);
    apply(1, 1, 2'd3, 32'hFFFF_FFFF, 4'b0000);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_valid got %b want 0000", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_data[k] !== 32'h0 || cnt[k] !== 8'h0) begin
        errors++; $display("FAIL reset_lane%0d data %h cnt %0d want 0 0", k, out_data[k], cnt[k]);
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_steering();
    apply(0, 1, 2'd2, 32'hDEAD_BEEF, 4'b0000);
    checks++;
    if (obs_ready !== 1'b1 || out_valid !== 4'b0100 || out_data[2] !== 32'hDEAD_BEEF || cnt[2] !== 8'd1) begin
      errors++;
      $display("FAIL steer rdy %b valid %b data2 %h cnt2 %0d want 1 0100 deadbeef 1",
               obs_ready, out_valid, out_data[2], cnt[2]);
    end
    checks++;
    if (out_data[0] !== 32'h0 || out_data[1] !== 32'h0 || out_data[3] !== 32'h0 ||
        cnt[0] !== 8'd0 || cnt[1] !== 8'd0 || cnt[3] !== 8'd0) begin
      errors++; $display("FAIL steer_others lanes 0/1/3 disturbed");
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 2'd2, 32'h1234_5678, 4'b0000);
      checks++;
      if (obs_ready !== 1'b0 || out_data[2] !== 32'hDEAD_BEEF || cnt[2] !== 8'd1 || out_valid !== 4'b0100) begin
        errors++;
        $display("FAIL backpressure cyc%0d rdy %b data2 %h cnt2 %0d valid %b want 0 deadbeef 1 0100",
                 i, obs_ready, out_data[2], cnt[2], out_valid);
      end
    end
    apply(0, 1, 2'd1, 32'hCAFE_0001, 4'b0000);
    checks++;
    if (obs_ready !== 1'b1 || out_valid !== 4'b0110 || out_data[1] !== 32'hCAFE_0001 || cnt[1] !== 8'd1) begin
      errors++;
      $display("FAIL other_lane rdy %b valid %b data1 %h cnt1 %0d want 1 0110 cafe0001 1",
               obs_ready, out_valid, out_data[1], cnt[1]);
    end
  endtask

  task automatic test_throughput();
    apply(0, 0, 2'd0, 32'h0, 4'b1111);
    checks++;
    if (out_valid !== 4'b0000) begin
      errors++; $display("FAIL drain_all valid %b want 0000", out_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      apply(0, 1, 2'd0, 32'(i), 4'b0001);
      checks++;
      if (obs_ready !== 1'b1 || out_data[0] !== 32'(i) || out_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL throughput word%0d rdy %b data0 %h valid0 %b want 1 %h 1",
                 i, obs_ready, out_data[0], out_valid[0], 32'(i));
      end
    end
    checks++;
    if (cnt[0] !== 8'd4) begin
      errors++; $display("FAIL throughput_cnt got %0d want 4", cnt[0]);
    end
  endtask

  task automatic test_wrap_reset();
    int start;
    start = int'(cnt[3]);
    for (int i = 0; i < CNT_MOD; i++)
      apply(0, 1, 2'd3, $urandom, 4'b1000);
    checks++;
    if (cnt[3] !== 8'(start) || out_data[3] !== m_word[3]) begin
      errors++;
      $display("FAIL wrap cnt3 %0d data3 %h want %0d %h", cnt[3], out_data[3], start, m_word[3]);
    end
    apply(0, 1, 2'd0, 32'hAAAA_0000, 4'b0000);
    apply(0, 1, 2'd1, 32'hBBBB_1111, 4'b0000);
    checks++;
    if (out_valid[1:0] !== 2'b11) begin
      errors++; $display("FAIL preload valid %b want xx11", out_valid);
    end
    apply(1, 1, 2'd2, 32'h5555_5555, 4'b0000);
    checks++;
    if (out_valid !== 4'b0000 || cnt[0] !== 8'd0 || cnt[1] !== 8'd0 || cnt[2] !== 8'd0 || cnt[3] !== 8'd0) begin
      errors++;
      $display("FAIL midreset valid %b cnt %0d %0d %0d %0d want 0000 0 0 0 0",
               out_valid, cnt[0], cnt[1], cnt[2], cnt[3]);
    end
  endtask

`ifdef WR_DEMUX_PARITY_EN
  task automatic test_parity();
    apply(0, 1, 2'd1, 32'h0000_0007, 4'b0000);
    checks++;
    if (out_par[1] !== 1'b1) begin
      errors++; $display("FAIL parity_odd got %b want 1", out_par[1]);
    end
    apply(0, 1, 2'd1, 32'h0000_0003, 4'b0010);
    checks++;
    if (out_par[1] !== 1'b0) begin
      errors++; $display("FAIL parity_even got %b want 0", out_par[1]);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 63) == 0), 1'($urandom), 2'($urandom), $urandom, 4'($urandom));
      checks++;
      if (obs_ready !== exp_ready) begin
        errors++; $display("FAIL rand_ready cyc%0d got %b want %b", i, obs_ready, exp_ready);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (out_valid[k] !== m_full[k] || out_data[k] !== m_word[k] || cnt[k] !== 8'(m_count[k])
`ifdef WR_DEMUX_PARITY_EN
            || out_par[k] !== m_par[k]
`endif
           ) begin
          errors++;
          $display("FAIL rand_lane%0d cyc%0d valid %b data %h cnt %0d want %b %h %0d",
                   k, i, out_valid[k], out_data[k], cnt[k], m_full[k], m_word[k], m_count[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0; m_word[k] = '0; m_count[k] = 0; m_par[k] = 0;
    end
    test_reset();
    test_steering();
    test_backpressure();
    test_throughput();
    test_wrap_reset();
`ifdef WR_DEMUX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
